// File: rtl/ps2_defs.sv
// Shared constants and bit-FSM encoding for the PS/2 receive path.
package ps2_defs;

   localparam logic [7:0] PS2_EXT = 8'hE0;
   localparam logic [7:0] PS2_BRK = 8'hF0;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      DATA   = 2'd1,
      PARITY = 2'd2,
      STOP   = 2'd3
   } bit_state_e;

   // Odd parity over data+parity, and the stop bit must be high.
   function automatic logic frame_ok(input logic [7:0] data,
                                     input logic       par,
                                     input logic       stop);
      return (^{data, par}) & stop;
   endfunction

endpackage

// File: rtl/ps2_frame_rx.sv
// PS/2 bit-level frame receiver: start, 8 data bits LSB-first, odd parity,
// stop. Produces a one-cycle frame_done with the byte, or a one-cycle
// frame_err on a parity/stop failure or an inter-strobe timeout.
//
// state  | meaning
// IDLE   | waiting for a start bit (strobe with data low)
// DATA   | shifting in the 8 data bits, LSB first
// PARITY | next strobe carries the parity bit
// STOP   | next strobe carries the stop bit; frame is judged here
module ps2_frame_rx
   import ps2_defs::*;
#(
   parameter int TIMEOUT_CYCLES = 100000
) (
   input  logic       clk,
   input  logic       reset1,
   input  logic       kb_clk_fall_i,
   input  logic       kb_data_i,
   output logic       frame_done_o,
   output logic [7:0] frame_byte_o,
   output logic       frame_err_o
);

   localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
   localparam logic [TW-1:0] TO_MAX = TW'(TIMEOUT_CYCLES);

   bit_state_e    state_q;
   logic [7:0]    shift_q;
   logic [2:0]    cnt_q;
   logic          parity_q;
   logic [TW-1:0] to_q;
   logic          done_q;
   logic [7:0]    byte_q;
   logic          err_q;

   // Bit FSM, shift register, frame check and stall timeout.
   always_ff @(posedge clk) begin
      if (!reset1) begin
         state_q  <= IDLE;
         shift_q  <= '0;
         cnt_q    <= '0;
         parity_q <= 1'b0;
         to_q     <= '0;
         done_q   <= 1'b0;
         byte_q   <= '0;
         err_q    <= 1'b0;
      end else begin
         done_q <= 1'b0;
         err_q  <= 1'b0;

         // A strobe landing on the terminal count wins over the timeout.
         if (kb_clk_fall_i || state_q == IDLE) begin
            to_q <= '0;
         end else if (to_q == TO_MAX) begin
            to_q    <= '0;
            state_q <= IDLE;
            err_q   <= 1'b1;
         end else begin
            to_q <= to_q + TW'(1);
         end

         if (kb_clk_fall_i) begin
            unique case (state_q)
               IDLE: begin
                  if (!kb_data_i) begin
                     state_q <= DATA;
                     cnt_q   <= '0;
                  end
               end
               DATA: begin
                  shift_q <= {kb_data_i, shift_q[7:1]};
                  cnt_q   <= cnt_q + 3'd1;
                  if (cnt_q == 3'd7) state_q <= PARITY;
               end
               PARITY: begin
                  parity_q <= kb_data_i;
                  state_q  <= STOP;
               end
               STOP: begin
                  state_q <= IDLE;
                  if (frame_ok(shift_q, parity_q, kb_data_i)) begin
                     done_q <= 1'b1;
                     byte_q <= shift_q;
                  end else begin
                     err_q <= 1'b1;
                  end
               end
               default: state_q <= IDLE;
            endcase
         end
      end
   end

   assign frame_done_o = done_q;
   assign frame_byte_o = byte_q;
   assign frame_err_o  = err_q;

endmodule

// File: rtl/ps2_rx_ctrl.sv
// PS/2 keyboard receive controller: frame receiver plus E0/F0 prefix folding.
// Emits one key event per physical key action and holds the last scan code.
module ps2_rx_ctrl
   import ps2_defs::*;
#(
   parameter int TIMEOUT_CYCLES = 100000
) (
   input  logic       clk,
   input  logic       reset1,
   input  logic       kb_clk_fall,
   input  logic       kb_data,
   output logic [7:0] display_o,
   output logic       key_valid,
   output logic       key_break,
   output logic       key_ext,
   output logic       frame_err
);

   logic       rx_done;
   logic [7:0] rx_byte;
   logic       rx_err;

   logic       ext_pend_q;
   logic       brk_pend_q;
   logic [7:0] display_q;
   logic       valid_q;
   logic       break_q;
   logic       ext_q;

   ps2_frame_rx #(
      .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
   ) u_rx (
      .clk          (clk),
      .reset1       (reset1),
      .kb_clk_fall_i(kb_clk_fall),
      .kb_data_i    (kb_data),
      .frame_done_o (rx_done),
      .frame_byte_o (rx_byte),
      .frame_err_o  (rx_err)
   );

   // Prefix decoder: prefixes accumulate until a real scan code arrives;
   // any frame error drops them so a corrupted sequence cannot leak flags.
   always_ff @(posedge clk) begin
      if (!reset1) begin
         ext_pend_q <= 1'b0;
         brk_pend_q <= 1'b0;
         display_q  <= 8'h00;
         valid_q    <= 1'b0;
         break_q    <= 1'b0;
         ext_q      <= 1'b0;
      end else begin
         valid_q <= 1'b0;
         if (rx_err) begin
            ext_pend_q <= 1'b0;
            brk_pend_q <= 1'b0;
         end else if (rx_done) begin
            if (rx_byte == PS2_EXT) begin
               ext_pend_q <= 1'b1;
            end else if (rx_byte == PS2_BRK) begin
               brk_pend_q <= 1'b1;
            end else begin
               display_q  <= rx_byte;
               ext_q      <= ext_pend_q;
               break_q    <= brk_pend_q;
               valid_q    <= 1'b1;
               ext_pend_q <= 1'b0;
               brk_pend_q <= 1'b0;
            end
         end
      end
   end

   assign display_o = display_q;
   assign key_valid = valid_q;
   assign key_break = break_q;
   assign key_ext   = ext_q;
   assign frame_err = rx_err;

endmodule
